// File: rtl/ts_demuxer.sv
// ts_demuxer
//   Splits the tagged pseudo-TS stream from the 4-channel muxer into four
//   per-channel TS byte streams. The source channel comes from the tagged
//   sync byte (SYNC_TAG_BASE | ch). The demuxer checks packet framing and
//   keeps lock and error status.
//
//   Optional build macro: TS_DEMUX_RESTORE_SYNC_EN
//     defined   -> each packet start byte is emitted as 8'h47
//     undefined -> the tagged sync byte is passed through unchanged
//
// Ports (all synchronous to SYS_CLK):
//   SYS_CLK      system clock
//   RST          synchronous reset, active-high
//   DATA_IN      pseudo-TS byte
//   D_VALID_IN   DATA_IN qualifier; idle gaps are allowed at any byte
//   P_SYNC_IN    first byte of a packet; only meaningful with D_VALID_IN
//   CH_ENABLE    per-channel output enable, sampled at each packet start
//   DATA_OUT     {ch3,ch2,ch1,ch0} byte lanes; a lane holds its value when idle
//   D_VALID_OUT  per-lane byte valid, one cycle after the input byte
//   P_SYNC_OUT   per-lane packet-start flag
//   PKT_DONE     per-lane pulse on the last byte of a complete packet
//   LOCK         framing locked (LOCK_PKTS good packets since the last error)
//   ERR_CNT      saturating framing error count
module ts_demuxer #(
  parameter int         PKT_LEN       = 188,
  parameter logic [7:0] SYNC_TAG_BASE = 8'h44,
  parameter int         LOCK_PKTS     = 2
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        D_VALID_IN,
  input  logic        P_SYNC_IN,
  input  logic [3:0]  CH_ENABLE,
  output logic [31:0] DATA_OUT,
  output logic [3:0]  D_VALID_OUT,
  output logic [3:0]  P_SYNC_OUT,
  output logic [3:0]  PKT_DONE,
  output logic        LOCK,
  output logic [15:0] ERR_CNT
);

  localparam int CNT_W  = $clog2(PKT_LEN);
  localparam int GOOD_W = $clog2(LOCK_PKTS + 1);

  typedef enum logic [1:0] {HUNT, PAYLOAD, EXPECT} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]         ch_reg, ch_next;
  logic               en_reg, en_next;

  logic [31:0]        data_out_reg;
  logic [3:0]         d_valid_out_reg;
  logic [3:0]         p_sync_out_reg;
  logic [3:0]         pkt_done_reg;
  logic               lock_reg;
  logic [15:0]        err_cnt_reg;
  logic [GOOD_W-1:0]  good_cnt_reg;

  // Per-byte decode
  logic       tag_ok;
  logic       is_start;
  logic       last_byte;
  logic [7:0] sync_byte;

  // Output-comb results, registered below for the fixed 1-cycle latency
  logic       emit;
  logic [1:0] emit_ch;
  logic       emit_en;
  logic [7:0] emit_data;
  logic       emit_sync;
  logic       emit_done;
  logic       err;

  assign tag_ok    = (DATA_IN[7:2] == SYNC_TAG_BASE[7:2]);
  assign is_start  = P_SYNC_IN && tag_ok;
  assign last_byte = (cnt_reg == CNT_W'(PKT_LEN - 1));

`ifdef TS_DEMUX_RESTORE_SYNC_EN
  assign sync_byte = 8'h47;
`else
  assign sync_byte = DATA_IN;
`endif

  // State register
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_reg <= HUNT;
      cnt_reg   <= '0;
      ch_reg    <= 2'd0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ch_reg    <= ch_next;
      en_reg    <= en_next;
    end
  end

  // Next-state logic; idle cycles leave everything as is
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ch_next    = ch_reg;
    en_next    = en_reg;
    if (D_VALID_IN) begin
      case (state_reg)
        HUNT: begin
          if (is_start) begin
            state_next = PAYLOAD;
            cnt_next   = CNT_W'(1);
            ch_next    = DATA_IN[1:0];
            en_next    = CH_ENABLE[DATA_IN[1:0]];
          end
        end
        PAYLOAD: begin
          if (P_SYNC_IN) begin
            // Truncated packet: the same byte may open a new packet
            if (is_start) begin
              cnt_next = CNT_W'(1);
              ch_next  = DATA_IN[1:0];
              en_next  = CH_ENABLE[DATA_IN[1:0]];
            end else begin
              state_next = HUNT;
              cnt_next   = '0;
            end
          end else if (last_byte) begin
            state_next = EXPECT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        EXPECT: begin
          if (is_start) begin
            state_next = PAYLOAD;
            cnt_next   = CNT_W'(1);
            ch_next    = DATA_IN[1:0];
            en_next    = CH_ENABLE[DATA_IN[1:0]];
          end else begin
            state_next = HUNT;
          end
        end
        default: begin
          state_next = HUNT;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output logic: which byte goes where, and whether this byte is an error
  always_comb begin
    emit      = 1'b0;
    emit_ch   = ch_reg;
    emit_en   = en_reg;
    emit_data = DATA_IN;
    emit_sync = 1'b0;
    emit_done = 1'b0;
    err       = 1'b0;
    if (D_VALID_IN) begin
      case (state_reg)
        HUNT: begin
          if (is_start) begin
            emit      = 1'b1;
            emit_sync = 1'b1;
            emit_ch   = DATA_IN[1:0];
            emit_en   = CH_ENABLE[DATA_IN[1:0]];
            emit_data = sync_byte;
          end else if (P_SYNC_IN) begin
            err = 1'b1;
          end
        end
        PAYLOAD: begin
          if (P_SYNC_IN) begin
            err = 1'b1;
            if (is_start) begin
              emit      = 1'b1;
              emit_sync = 1'b1;
              emit_ch   = DATA_IN[1:0];
              emit_en   = CH_ENABLE[DATA_IN[1:0]];
              emit_data = sync_byte;
            end
          end else begin
            emit      = 1'b1;
            emit_done = last_byte;
          end
        end
        EXPECT: begin
          if (is_start) begin
            emit      = 1'b1;
            emit_sync = 1'b1;
            emit_ch   = DATA_IN[1:0];
            emit_en   = CH_ENABLE[DATA_IN[1:0]];
            emit_data = sync_byte;
          end else begin
            err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-lane output registers. A disabled channel still has its framing
  // tracked, but its lane stays silent and keeps its last data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic lane_sel;
      assign lane_sel = emit && emit_en && (emit_ch == 2'(gi));

      always_ff @(posedge SYS_CLK) begin
        if (RST) begin
          data_out_reg[gi*8 +: 8] <= 8'h00;
          d_valid_out_reg[gi]     <= 1'b0;
          p_sync_out_reg[gi]      <= 1'b0;
          pkt_done_reg[gi]        <= 1'b0;
        end else begin
          d_valid_out_reg[gi] <= lane_sel;
          p_sync_out_reg[gi]  <= lane_sel && emit_sync;
          pkt_done_reg[gi]    <= lane_sel && emit_done;
          if (lane_sel) begin
            data_out_reg[gi*8 +: 8] <= emit_data;
          end
        end
      end
    end
  endgenerate

  // Lock and error status. Completed packets count toward lock even when
  // their channel is disabled. An error and a completion never coincide.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      err_cnt_reg  <= 16'h0000;
      good_cnt_reg <= '0;
      lock_reg     <= 1'b0;
    end else if (err) begin
      if (err_cnt_reg != 16'hFFFF) begin
        err_cnt_reg <= err_cnt_reg + 16'd1;
      end
      good_cnt_reg <= '0;
      lock_reg     <= 1'b0;
    end else if (emit_done) begin
      if (good_cnt_reg != GOOD_W'(LOCK_PKTS)) begin
        good_cnt_reg <= good_cnt_reg + GOOD_W'(1);
      end
      if (good_cnt_reg >= GOOD_W'(LOCK_PKTS - 1)) begin
        lock_reg <= 1'b1;
      end
    end
  end

  assign DATA_OUT    = data_out_reg;
  assign D_VALID_OUT = d_valid_out_reg;
  assign P_SYNC_OUT  = p_sync_out_reg;
  assign PKT_DONE    = pkt_done_reg;
  assign LOCK        = lock_reg;
  assign ERR_CNT     = err_cnt_reg;

endmodule
